// File: rtl/fpu_dispatch_if.sv
// Command/result bus between the FPU register block, the dispatcher and the arithmetic unit.
// The slave view belongs to fpu_dispatch; the master view drives commands and unit responses.
interface fpu_dispatch_if;
    logic        cfg_fpu_val;
    logic [3:0]  cfg_fpu_cmd;
    logic [31:0] cfg_fpu_din1;
    logic [31:0] cfg_fpu_din2;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic        fpu_busy;
    logic [4:0]  fpu_flags;
    logic        fpu_timeout;
    logic        flag_clr;
    logic        unit_start;
    logic [2:0]  unit_op;
    logic [31:0] unit_opa;
    logic [31:0] unit_opb;
    logic        unit_done;
    logic [31:0] unit_result;
    logic [4:0]  unit_flags;

    modport slave (
        input  cfg_fpu_val, cfg_fpu_cmd, cfg_fpu_din1, cfg_fpu_din2, flag_clr,
        input  unit_done, unit_result, unit_flags,
        output fpu_done, fpu_result, fpu_busy, fpu_flags, fpu_timeout,
        output unit_start, unit_op, unit_opa, unit_opb
    );

    modport master (
        output cfg_fpu_val, cfg_fpu_cmd, cfg_fpu_din1, cfg_fpu_din2, flag_clr,
        output unit_done, unit_result, unit_flags,
        input  fpu_done, fpu_result, fpu_busy, fpu_flags, fpu_timeout,
        input  unit_start, unit_op, unit_opa, unit_opb
    );
endinterface

// File: rtl/fpu_dispatch.sv
// FPU command sequencer: runs MIN/MAX/SGNJ locally, dispatches arithmetic ops to a
// multi-cycle unit under a watchdog, and returns result plus sticky IEEE flags.
module fpu_dispatch #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 16
) (
    input logic           mclk,
    input logic           rst,
    fpu_dispatch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0]       OP_MIN   = 4'd5;
    localparam logic [3:0]       OP_MAX   = 4'd6;
    localparam logic [3:0]       OP_SGNJ  = 4'd7;
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state, state_n;
    logic [2:0]       op_r, op_n;
    logic [31:0]      opa_r, opa_n, opb_r, opb_n;
    logic [31:0]      result_r, result_n;
    logic [4:0]       flags_r, flags_n, flag_upd;
    logic             timeout_r, timeout_n, set_timeout;
    logic [CNT_W-1:0] cnt_r, cnt_n;

    logic [31:0] a, b;
    logic        a_nan, b_nan, a_lt_b;
    logic [31:0] loc_res;
    logic        loc_nv;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    assign a     = bus.cfg_fpu_din1;
    assign b     = bus.cfg_fpu_din2;
    assign a_nan = is_nan(a);
    assign b_nan = is_nan(b);

    // Sign-magnitude ordering; differing signs put -0.0 below +0.0 naturally.
    always_comb begin
        if (a[31] != b[31])
            a_lt_b = a[31];
        else if (a[31])
            a_lt_b = a[30:0] > b[30:0];
        else
            a_lt_b = a[30:0] < b[30:0];
    end

    always_comb begin
        loc_res = QNAN;
        loc_nv  = 1'b1;
        case (bus.cfg_fpu_cmd)
            OP_MIN, OP_MAX: begin
                loc_nv = is_snan(a) | is_snan(b);
                if (a_nan && b_nan)
                    loc_res = QNAN;
                else if (a_nan)
                    loc_res = b;
                else if (b_nan)
                    loc_res = a;
                else
                    loc_res = ((bus.cfg_fpu_cmd == OP_MIN) == a_lt_b) ? a : b;
            end
            OP_SGNJ: begin
                loc_nv  = 1'b0;
                loc_res = {b[31], a[30:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n     = state;
        op_n        = op_r;
        opa_n       = opa_r;
        opb_n       = opb_r;
        result_n    = result_r;
        cnt_n       = cnt_r;
        flag_upd    = '0;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cfg_fpu_val) begin
                    op_n  = bus.cfg_fpu_cmd[2:0];
                    opa_n = a;
                    opb_n = b;
                    if (bus.cfg_fpu_cmd < OP_MIN) begin
                        state_n = ISSUE;
                    end else begin
                        result_n = loc_res;
                        flag_upd = {loc_nv, 4'b0000};
                        state_n  = DONE;
                    end
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (bus.unit_done) begin
                    result_n = bus.unit_result;
                    flag_upd = bus.unit_flags;
                    state_n  = DONE;
                end else if (cnt_r == CNT_LAST) begin
                    result_n    = QNAN;
                    set_timeout = 1'b1;
                    state_n     = DONE;
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // A same-cycle update re-sets its bits after the clear.
        flags_n   = (bus.flag_clr ? 5'b00000 : flags_r) | flag_upd;
        timeout_n = (bus.flag_clr ? 1'b0 : timeout_r) | set_timeout;
    end

    always_ff @(posedge mclk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            op_r      <= '0;
            opa_r     <= '0;
            opb_r     <= '0;
            result_r  <= '0;
            flags_r   <= '0;
            timeout_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            op_r      <= op_n;
            opa_r     <= opa_n;
            opb_r     <= opb_n;
            result_r  <= result_n;
            flags_r   <= flags_n;
            timeout_r <= timeout_n;
            cnt_r     <= cnt_n;
        end
    end

    assign bus.fpu_done    = (state == DONE);
    assign bus.fpu_busy    = (state != IDLE);
    assign bus.unit_start  = (state == ISSUE);
    assign bus.unit_op     = op_r;
    assign bus.unit_opa    = opa_r;
    assign bus.unit_opb    = opb_r;
    assign bus.fpu_result  = result_r;
    assign bus.fpu_flags   = flags_r;
    assign bus.fpu_timeout = timeout_r;
endmodule

// File: tb/tb_fpu_dispatch.sv
// Randomized bench for fpu_dispatch: transactions are predicted from real-valued
// comparisons and latency arithmetic, then checked cycle by cycle at the falling edge.
module tb_fpu_dispatch;
    localparam int unsigned TO   = 8;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic mclk = 1'b0;
    logic rst;
    always #5 mclk = ~mclk;

    fpu_dispatch_if bus();

    fpu_dispatch #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_result;
    logic [4:0]  m_flags;
    logic        m_timeout;

    logic [31:0] specials [8] = '{32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h7F80_0001,
                                  32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'hBF80_0000};

    function automatic real f2r(input logic [31:0] x);
        real mag;
        int  e;
        e = int'(x[30:23]);
        if (e == 255)
            mag = 1.0e300;
        else if (e == 0)
            mag = real'(x[22:0]) * (2.0 ** -149.0);
        else
            mag = (real'(x[22:0]) + 8388608.0) * (2.0 ** (real'(e) - 150.0));
        return x[31] ? -mag : mag;
    endfunction

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic bit is_snan(input logic [31:0] x);
        return is_nan(x) && (x[22] == 1'b0);
    endfunction

    function automatic logic [31:0] ref_minmax(input logic [31:0] a, input logic [31:0] b,
                                               input bit is_max);
        real ra, rb;
        if (is_nan(a) && is_nan(b)) return QNAN;
        if (is_nan(a)) return b;
        if (is_nan(b)) return a;
        ra = f2r(a);
        rb = f2r(b);
        if (ra < rb) return is_max ? b : a;
        if (ra > rb) return is_max ? a : b;
        if (a == b) return a;
        return (a[31] ^ is_max) ? a : b;
    endfunction

    function automatic logic [31:0] rand_operand();
        if ($urandom_range(0, 1) == 1)
            return specials[$urandom_range(0, 7)];
        return $urandom;
    endfunction

    // One full command; k is the WAIT-cycle index in which unit_done is raised (-1: never).
    task automatic do_cmd(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input int k, input logic [31:0] ures, input logic [4:0] uflg,
                          input bit extra_val, input bit late_done, input bit clr_with,
                          input string name);
        int          exp_cyc, done_cyc, n_done, n_start;
        bit          unit, to, hit;
        logic [31:0] e_res;
        logic [4:0]  upd;
        unit = (cmd < 4'd5);
        to   = 1'b0;
        upd  = 5'b00000;
        if (!unit) begin
            exp_cyc = 1;
            case (cmd)
                4'd5:    begin e_res = ref_minmax(a, b, 1'b0); upd = {is_snan(a) | is_snan(b), 4'b0}; end
                4'd6:    begin e_res = ref_minmax(a, b, 1'b1); upd = {is_snan(a) | is_snan(b), 4'b0}; end
                4'd7:    e_res = {b[31], a[30:0]};
                default: begin e_res = QNAN; upd = 5'b10000; end
            endcase
        end else if (k >= 0 && k < int'(TO)) begin
            exp_cyc = 3 + k;
            e_res   = ures;
            upd     = uflg;
        end else begin
            exp_cyc = 2 + int'(TO);
            e_res   = QNAN;
            to      = 1'b1;
        end
        if (clr_with) begin
            m_flags   = 5'b00000;
            m_timeout = 1'b0;
        end
        m_result  = e_res;
        m_flags   = m_flags | upd;
        m_timeout = m_timeout | to;

        bus.cfg_fpu_val  = 1'b1;
        bus.cfg_fpu_cmd  = cmd;
        bus.cfg_fpu_din1 = a;
        bus.cfg_fpu_din2 = b;
        bus.flag_clr     = clr_with;
        done_cyc = -1;
        n_done   = 0;
        n_start  = 0;
        for (int cyc = 1; cyc <= exp_cyc + 2; cyc++) begin
            @(negedge mclk);
            bus.flag_clr = 1'b0;
            if (cyc == 1 && unit) begin
                n_cmp++;
                if ({bus.unit_start, bus.unit_op, bus.unit_opa, bus.unit_opb} !== {1'b1, cmd[2:0], a, b}) begin
                    n_err++;
                    $display("FAIL %s issue: start/op/opa/opb got %b/%0d/%h/%h want 1/%0d/%h/%h",
                             name, bus.unit_start, bus.unit_op, bus.unit_opa, bus.unit_opb, cmd[2:0], a, b);
                end
            end
            if (bus.unit_start === 1'b1) n_start++;
            if (bus.fpu_done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            n_cmp++;
            if (bus.fpu_busy !== (cyc <= exp_cyc)) begin
                n_err++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, cyc, bus.fpu_busy, cyc <= exp_cyc);
            end
            hit = unit && (cyc - 2 == k);
            bus.unit_done   = hit || (late_done && cyc >= exp_cyc);
            bus.unit_result = hit ? ures : $urandom;
            bus.unit_flags  = hit ? uflg : 5'($urandom);
            bus.cfg_fpu_val = extra_val && (cyc == 3);
            bus.cfg_fpu_cmd = 4'($urandom_range(0, 7));
            bus.cfg_fpu_din1 = $urandom;
            bus.cfg_fpu_din2 = $urandom;
        end
        bus.unit_done   = 1'b0;
        bus.cfg_fpu_val = 1'b0;

        n_cmp++;
        if (done_cyc != exp_cyc || n_done != 1) begin
            n_err++;
            $display("FAIL %s done: got cycle %0d count %0d want cycle %0d count 1", name, done_cyc, n_done, exp_cyc);
        end
        n_cmp++;
        if (n_start != int'(unit)) begin
            n_err++;
            $display("FAIL %s start count: got %0d want %0d", name, n_start, int'(unit));
        end
        n_cmp++;
        if (bus.fpu_result !== m_result) begin
            n_err++;
            $display("FAIL %s result: got %h want %h", name, bus.fpu_result, m_result);
        end
        n_cmp++;
        if ({bus.fpu_flags, bus.fpu_timeout} !== {m_flags, m_timeout}) begin
            n_err++;
            $display("FAIL %s flags/timeout: got %b/%b want %b/%b", name, bus.fpu_flags, bus.fpu_timeout, m_flags, m_timeout);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({bus.fpu_done, bus.fpu_busy, bus.unit_start, bus.unit_op, bus.unit_opa, bus.unit_opb,
             bus.fpu_result, bus.fpu_flags, bus.fpu_timeout} !== '0) begin
            n_err++;
            $display("FAIL %s outputs: got done=%b busy=%b start=%b op=%0d opa=%h opb=%h res=%h flg=%b to=%b want all 0",
                     name, bus.fpu_done, bus.fpu_busy, bus.unit_start, bus.unit_op, bus.unit_opa,
                     bus.unit_opb, bus.fpu_result, bus.fpu_flags, bus.fpu_timeout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge mclk);
        check_all_zero("reset");
        rst = 1'b0;
        m_result  = '0;
        m_flags   = '0;
        m_timeout = 1'b0;
        @(negedge mclk);
    endtask

    task automatic test_add();
        do_cmd(4'd0, 32'h3F80_0000, 32'h4000_0000, 4, 32'h4040_0000, 5'b00000, 0, 0, 0, "add");
    endtask

    task automatic test_local();
        do_cmd(4'd5, 32'h8000_0000, 32'h0000_0000, -1, '0, '0, 0, 0, 0, "min_zero");
        do_cmd(4'd6, 32'h7F80_0001, 32'h3F80_0000, -1, '0, '0, 0, 0, 0, "max_snan");
        do_cmd(4'd7, 32'h3F80_0000, 32'h8000_0000, -1, '0, '0, 0, 0, 0, "sgnj");
        do_cmd(4'd6, 32'h7FC0_0000, 32'hFFC0_0001, -1, '0, '0, 0, 0, 0, "max_2nan");
    endtask

    task automatic test_illegal();
        do_cmd(4'hC, $urandom, $urandom, -1, '0, '0, 0, 0, 0, "illegal");
    endtask

    task automatic test_flag_clr();
        bus.flag_clr = 1'b1;
        @(negedge mclk);
        bus.flag_clr = 1'b0;
        m_flags   = 5'b00000;
        m_timeout = 1'b0;
        n_cmp++;
        if ({bus.fpu_flags, bus.fpu_timeout} !== 6'b0) begin
            n_err++;
            $display("FAIL flag_clr: got %b/%b want 00000/0", bus.fpu_flags, bus.fpu_timeout);
        end
    endtask

    task automatic test_timeout();
        do_cmd(4'd3, 32'h4000_0000, 32'h0000_0000, -1, '0, '0, 0, 1, 0, "timeout");
    endtask

    task automatic test_back_to_back();
        do_cmd(4'd1, $urandom, $urandom, int'(TO) - 1, 32'h1234_5678, 5'b00001, 1, 0, 0, "coincide");
        do_cmd(4'hF, $urandom, $urandom, -1, '0, '0, 0, 0, 1, "clr_vs_set");
    endtask

    task automatic test_reset_mid();
        bus.cfg_fpu_val  = 1'b1;
        bus.cfg_fpu_cmd  = 4'd2;
        bus.cfg_fpu_din1 = $urandom;
        bus.cfg_fpu_din2 = $urandom;
        @(negedge mclk);
        bus.cfg_fpu_val = 1'b0;
        repeat (3) @(negedge mclk);
        rst = 1'b1;
        @(negedge mclk);
        rst = 1'b0;
        check_all_zero("reset_mid");
        m_result  = '0;
        m_flags   = '0;
        m_timeout = 1'b0;
        do_cmd(4'd2, 32'h4000_0000, 32'h4040_0000, 2, 32'h40C0_0000, 5'b00000, 0, 0, 0, "mul_after_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [3:0] cmd;
            int         k;
            cmd = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            k   = int'($urandom_range(0, 10));
            do_cmd(cmd, rand_operand(), rand_operand(), k, $urandom, 5'($urandom),
                   (cmd < 4'd5) && (k >= 2) && ($urandom_range(0, 1) == 1), 0,
                   ($urandom_range(0, 5) == 0), "random");
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.cfg_fpu_val  = 1'b0;
        bus.cfg_fpu_cmd  = '0;
        bus.cfg_fpu_din1 = '0;
        bus.cfg_fpu_din2 = '0;
        bus.flag_clr     = 1'b0;
        bus.unit_done    = 1'b0;
        bus.unit_result  = '0;
        bus.unit_flags   = '0;
        test_reset();
        test_add();
        test_local();
        test_illegal();
        test_flag_clr();
        test_timeout();
        test_flag_clr();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got simulation still running want finished");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/fpu_dispatch.md
Name: fpu_dispatch

Overview:
Command sequencer between the FPU register block and the FPU arithmetic unit.
- Captures a command pulse and its operands, and runs sign/min/max ops locally in one cycle.
- Dispatches ADD/SUB/MUL/DIV/SQRT to a multi-cycle arithmetic unit over a start/done handshake.
- Bounds that unit with a watchdog, and returns a one-cycle done pulse, the result and accumulated IEEE flags to the register block.

Parameters:
TIMEOUT_CYC, 255, max cycles waited for unit_done after unit_start before abort (1..65535)
CNT_W, 16, watchdog counter width

Ports:
mclk  in  1  clock; single clock domain
rst  in  1  synchronous reset, active-high
cfg_fpu_val  in  1  one-cycle command strobe
cfg_fpu_cmd  in  4  opcode
cfg_fpu_din1  in  32  operand A (IEEE-754 single)
cfg_fpu_din2  in  32  operand B
fpu_done  out  1  one-cycle completion pulse
fpu_result  out  32  result, held until next completion
fpu_busy  out  1  command in flight
fpu_flags  out  5  sticky {NV,DZ,OF,UF,NX}
fpu_timeout  out  1  sticky watchdog abort
flag_clr  in  1  clears fpu_flags and fpu_timeout
unit_start  out  1  one-cycle start to arithmetic unit
unit_op  out  3  0 ADD,1 SUB,2 MUL,3 DIV,4 SQRT
unit_opa  out  32  registered operand A
unit_opb  out  32  registered operand B
unit_done  in  1  unit completion pulse
unit_result  in  32  valid with unit_done
unit_flags  in  5  valid with unit_done

Behaviour:
- Interface: one clock (mclk); reset is synchronous and active-high (rst).
- Reset: state IDLE; all outputs 0; operand/cmd registers and watchdog counter 0.
- Opcodes:
  - 0-4: unit ops.
  - 5 MIN, 6 MAX, 7 SGNJ (din1 magnitude, din2 sign): local ops.
  - 8-15: illegal.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - cfg_fpu_val=1 at edge T captures cmd/din1/din2; fpu_busy=1 from T+1.
  - Unit op -> ISSUE.
  - Local op -> DONE, computed result registered at T.
  - Illegal op -> DONE with result 0x7FC00000, NV set.
- ISSUE: one cycle (T+1); unit_start=1, unit_op=cmd[2:0]; watchdog cleared -> WAIT.
- WAIT: counter increments every cycle.
  - unit_done=1 -> latch unit_result, OR unit_flags into fpu_flags -> DONE.
  - Counter reaches TIMEOUT_CYC-1 without unit_done -> result 0x7FC00000, fpu_timeout=1 -> DONE.
  - unit_done and timeout in the same cycle: unit_done wins.
- DONE: one cycle; fpu_done=1 -> IDLE. fpu_busy stays 1 through DONE and drops the cycle after.
- Latency:
  - Local/illegal: fpu_done in cycle T+1.
  - Unit: unit_start in T+1; fpu_done the cycle after unit_done is sampled; minimum T+3.
- cfg_fpu_val outside IDLE: ignored; no queueing, no flag.
- unit_done outside WAIT: ignored.
- MIN/MAX:
  - -0.0 < +0.0.
  - One NaN operand -> return the other.
  - Both NaN -> 0x7FC00000.
  - Any signalling NaN (exp=FF, frac!=0, frac[22]=0) sets NV.
  - Otherwise compare by sign-magnitude.
- SGNJ: {din2[31], din1[30:0]}; no flags.
- flag_clr:
  - Clears fpu_flags and fpu_timeout that cycle.
  - If a flag update coincides, the update wins; new bits are set.
- fpu_result: updated only on entry to DONE.
- rst mid-operation: returns to IDLE next edge; no fpu_done; unit_start low.

Test Plan:
- ADD din1=0x3F800000 din2=0x40000000 -> unit_start at T+1 with op=0, opa/opb as given. Model returns 0x40400000 after 5 cycles -> fpu_done one cycle later, fpu_result=0x40400000, busy drops the following cycle.
- MIN din1=0x80000000, din2=0x00000000 -> fpu_done at T+1, result 0x80000000, no unit_start. MAX with din1=0x7F800001 (sNaN), din2=0x3F800000 -> result 0x3F800000, fpu_flags=10000.
- cmd=0xC -> fpu_done at T+1, result 0x7FC00000, NV set. Then flag_clr=1 -> fpu_flags=0.
- DIV with unit_done never asserted, TIMEOUT_CYC=8 -> fpu_done 8 cycles after WAIT entry, result 0x7FC00000, fpu_timeout=1. A late unit_done is ignored.
- Second cfg_fpu_val while in WAIT -> ignored; exactly one unit_start and one fpu_done. Same test: unit_done coinciding with the timeout edge -> unit_result returned, fpu_timeout stays 0.
- rst asserted during WAIT -> next cycle state IDLE, all outputs 0. A following MUL completes normally.
